coh_noc_cfg_arbiter: RTL

//  Round-robin arbiter sharing the single NoC config register port (cfg_*) among NUM_REQ masters (boot loader, host, debug).

---
 rtl/coh_noc_pkg.sv | 14 +
 rtl/coh_noc_cfg_arbiter_if.sv | 38 +++
 rtl/coh_noc_rr_picker.sv | 31 +++
 rtl/coh_noc_cfg_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/coh_noc_pkg.sv
// Shared NoC types and constants used by the config-port arbiter.
// Holds the arbiter FSM state encoding and the read data returned on a timeout.
// No ports: this is a package imported by the arbiter RTL.
package coh_noc_pkg;

  typedef enum logic [1:0] {
    CFG_ARB_IDLE,
    CFG_ARB_ISSUE,
    CFG_ARB_RESP
  } cfg_arb_state_e;

  localparam logic [31:0] CFG_ARB_TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/coh_noc_cfg_arbiter_if.sv
// Bundle of requester-side and config-port signals for the config arbiter.
// Requester side: req_valid/write/addr/wdata in, req_ready/rsp_valid/rsp_rdata/rsp_err out.
// Config side: cfg_req/write/addr/wdata out, cfg_rdata/cfg_ready in. slave = arbiter, master = environment.
interface coh_noc_cfg_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_rdata;
  logic                           rsp_err;

  logic                           cfg_req;
  logic                           cfg_write;
  logic [ADDR_W-1:0]              cfg_addr;
  logic [DATA_W-1:0]              cfg_wdata;
  logic [DATA_W-1:0]              cfg_rdata;
  logic                           cfg_ready;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, cfg_rdata, cfg_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           cfg_req, cfg_write, cfg_addr, cfg_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, cfg_rdata, cfg_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           cfg_req, cfg_write, cfg_addr, cfg_wdata
  );

endinterface

// File: rtl/coh_noc_rr_picker.sv
// Combinational round-robin pick: first set valid_i bit scanning from ptr_i upward with wrap.
// Ports: valid_i[N], ptr_i -> gnt_vld_o (any valid), gnt_idx_o (winning index).
// Zero latency; holds no state, so the caller owns the pointer update.
module coh_noc_rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic          gnt_vld_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] cand;

  // Walk offsets from furthest to nearest so the nearest valid to ptr_i is
  // the last assignment and therefore wins.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    cand      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr_i) + i) % N);
      if (valid_i[cand]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/coh_noc_cfg_arbiter.sv
// Round-robin arbiter serialising NUM_REQ masters onto the single NoC config register port.
// Ports: clk/rst, bus (requesters + cfg port), config_locked in; busy, txn_count, err_count out.
// One access in flight: accept in IDLE, hold cfg_req in ISSUE until cfg_ready/timeout, pulse rsp in RESP.
module coh_noc_cfg_arbiter
  import coh_noc_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  coh_noc_cfg_arbiter_if.slave        bus,
  input  logic                        config_locked,
  output logic                        busy,
  output logic [31:0]                 txn_count,
  output logic [15:0]                 err_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [IW-1:0]      LAST_ID  = IW'(NUM_REQ - 1);

  cfg_arb_state_e     state_q;
  logic [IW-1:0]      rr_ptr_q;
  logic [IW-1:0]      owner_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic [TW-1:0]      tmo_q;
  logic               cfg_req_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [31:0]        txn_q;
  logic [15:0]        errc_q;

  logic               gnt_vld;
  logic [IW-1:0]      gnt_idx;
  logic               accept;
  logic [15:0]        errc_d;
  logic [IW-1:0]      rr_ptr_d;

  coh_noc_rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .valid_i   (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  // Accept is combinational so req_ready lands in the same cycle the grant is
  // made; it is masked during reset so no requester sees a phantom accept.
  assign accept   = (state_q == CFG_ARB_IDLE) && !rst && gnt_vld;
  assign errc_d   = (errc_q == 16'hFFFF) ? errc_q : errc_q + 16'd1;
  assign rr_ptr_d = (owner_q == LAST_ID) ? '0 : owner_q + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CFG_ARB_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      cfg_req_q   <= 1'b0;
      rsp_valid_q <= '0;
      txn_q       <= '0;
      errc_q      <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        CFG_ARB_IDLE: begin
          if (accept) begin
            owner_q <= gnt_idx;
            wr_q    <= bus.req_write[gnt_idx];
            addr_q  <= bus.req_addr[gnt_idx];
            wdata_q <= bus.req_wdata[gnt_idx];
            // Lock only matters for writes and only at accept time.
            if (bus.req_write[gnt_idx] && config_locked) begin
              rdata_q     <= '0;
              err_q       <= 1'b1;
              rsp_valid_q <= ONE_HOT0 << gnt_idx;
              state_q     <= CFG_ARB_RESP;
            end else begin
              tmo_q     <= '0;
              cfg_req_q <= 1'b1;
              state_q   <= CFG_ARB_ISSUE;
            end
          end
        end
        CFG_ARB_ISSUE: begin
          // cfg_ready takes priority over a timeout landing in the same cycle.
          if (bus.cfg_ready) begin
            rdata_q     <= wr_q ? '0 : bus.cfg_rdata;
            err_q       <= 1'b0;
            cfg_req_q   <= 1'b0;
            rsp_valid_q <= ONE_HOT0 << owner_q;
            state_q     <= CFG_ARB_RESP;
          end else if (tmo_q == TMO_LAST) begin
            rdata_q     <= DATA_W'(CFG_ARB_TIMEOUT_RDATA);
            err_q       <= 1'b1;
            cfg_req_q   <= 1'b0;
            rsp_valid_q <= ONE_HOT0 << owner_q;
            state_q     <= CFG_ARB_RESP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        CFG_ARB_RESP: begin
          txn_q    <= txn_q + 32'd1;
          if (err_q) errc_q <= errc_d;
          rr_ptr_q <= rr_ptr_d;
          state_q  <= CFG_ARB_IDLE;
        end
        default: begin
          state_q   <= CFG_ARB_IDLE;
          cfg_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = accept ? (ONE_HOT0 << gnt_idx) : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.cfg_req   = cfg_req_q;
  assign bus.cfg_write = cfg_req_q & wr_q;
  assign bus.cfg_addr  = addr_q;
  assign bus.cfg_wdata = wdata_q;

  assign busy      = (state_q != CFG_ARB_IDLE);
  assign txn_count = txn_q;
  assign err_count = errc_q;

endmodule
